// File: rtl/mem_dump_uart_pkg.sv
// Shared definitions for the memory-dump UART block: sequencing states and
// UART framing constants.
package mem_dump_uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_WAIT,
    ST_SEND,
    ST_FIN
  } state_e;

  localparam logic        UART_START     = 1'b0;
  localparam logic        UART_STOP      = 1'b1;
  localparam int unsigned FRAME_BITS     = 10;
  localparam int unsigned BYTES_PER_WORD = 4;

endpackage

// File: rtl/mem_dump_uart_tx.sv
// 8N1 byte serialiser: BAUD_DIV cycles per bit. Back-to-back frames are
// possible because ready also asserts in the final cycle of the stop bit.
module uart_tx_byte
  import mem_dump_uart_pkg::*;
#(
  parameter int unsigned BAUD_DIV = 434
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [7:0] data,
  output logic       ready,
  output logic       stop_ending,
  output logic       tx
);

  logic                  active;
  logic [FRAME_BITS-1:0] shreg;
  logic [15:0]           baud_cnt;
  logic [3:0]            bit_cnt;
  logic                  bit_end;
  logic                  last_bit;

  assign bit_end  = (baud_cnt == 16'(BAUD_DIV - 1));
  assign last_bit = (bit_cnt == 4'(FRAME_BITS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active   <= 1'b0;
      shreg    <= '1;
      baud_cnt <= '0;
      bit_cnt  <= '0;
    end else if (load) begin
      active   <= 1'b1;
      shreg    <= {UART_STOP, data, UART_START};
      baud_cnt <= '0;
      bit_cnt  <= '0;
    end else if (active) begin
      if (bit_end) begin
        baud_cnt <= '0;
        if (last_bit) begin
          active <= 1'b0;
        end else begin
          shreg   <= {UART_STOP, shreg[FRAME_BITS-1:1]};
          bit_cnt <= bit_cnt + 4'd1;
        end
      end else begin
        baud_cnt <= baud_cnt + 16'd1;
      end
    end
  end

  assign tx          = active ? shreg[0] : UART_STOP;
  assign ready       = !active || (bit_end && last_bit);
  // One cycle of warning before the frame ends, used to start the next fetch early.
  assign stop_ending = active && last_bit && (baud_cnt == 16'(BAUD_DIV - 2));

endmodule

// File: rtl/mem_dump_uart.sv
// Memory read-back over UART: reads a word range and sends each word as four
// 8N1 bytes, MSB byte first. Optional checksum trailer: MEM_DUMP_CHECKSUM_EN.
module mem_dump_uart
  import mem_dump_uart_pkg::*;
#(
  parameter int unsigned ADDR_W   = 12,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned BAUD_DIV = 434
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W:0]   word_count,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              tx,
  output logic              busy,
  output logic              done
);

  state_e            state, state_n;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W:0]   remaining;
  logic [DATA_W-1:0] word;
  logic [1:0]        byte_idx;
  logic              tail;
  logic              done_r;
  logic              uart_load, uart_ready, uart_stop_ending;
  logic [7:0]        tx_byte;
  logic              last_word, fetch_empty;
`ifdef MEM_DUMP_CHECKSUM_EN
  logic              csum_mode;
  logic [7:0]        csum;
`endif

  assign last_word   = (remaining == (ADDR_W+1)'(1));
  assign fetch_empty = (remaining == '0);

  always_comb begin
    tx_byte = word[{byte_idx, 3'b000} +: 8];
`ifdef MEM_DUMP_CHECKSUM_EN
    if (csum_mode) tx_byte = csum;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_n;
  end

  // Leaving SEND on stop_ending (not on frame end) keeps the inter-word gap at two cycles.
  always_comb begin
    state_n   = state;
    mem_rd_en = 1'b0;
    uart_load = 1'b0;
    unique case (state)
      ST_IDLE:  if (start) state_n = ST_FETCH;
      ST_FETCH: begin
        if (fetch_empty) begin
`ifdef MEM_DUMP_CHECKSUM_EN
          state_n = ST_SEND;
`else
          state_n = ST_FIN;
`endif
        end else begin
          mem_rd_en = 1'b1;
          state_n   = ST_WAIT;
        end
      end
      ST_WAIT:  state_n = ST_SEND;
      ST_SEND: begin
        if (tail) begin
          if (uart_stop_ending) begin
`ifdef MEM_DUMP_CHECKSUM_EN
            if (csum_mode)      state_n = ST_FIN;
            else if (last_word) state_n = ST_SEND;
            else                state_n = ST_FETCH;
`else
            state_n = last_word ? ST_FIN : ST_FETCH;
`endif
          end
        end else begin
          uart_load = uart_ready;
        end
      end
      ST_FIN:   state_n = ST_IDLE;
      default:  state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr      <= '0;
      remaining <= '0;
      word      <= '0;
      byte_idx  <= '0;
      tail      <= 1'b0;
      done_r    <= 1'b0;
`ifdef MEM_DUMP_CHECKSUM_EN
      csum_mode <= 1'b0;
      csum      <= '0;
`endif
    end else begin
      done_r <= (state == ST_FIN);
      if (state == ST_IDLE && start) begin
        addr      <= start_addr;
        remaining <= word_count;
        tail      <= 1'b0;
`ifdef MEM_DUMP_CHECKSUM_EN
        csum_mode <= 1'b0;
        csum      <= '0;
`endif
      end
`ifdef MEM_DUMP_CHECKSUM_EN
      if (state == ST_FETCH && fetch_empty) csum_mode <= 1'b1;
`endif
      if (state == ST_WAIT) begin
        word     <= mem_rdata;
        byte_idx <= 2'(BYTES_PER_WORD - 1);
        tail     <= 1'b0;
      end
      if (uart_load) begin
        byte_idx <= byte_idx - 2'd1;
        if (byte_idx == 2'd0) tail <= 1'b1;
`ifdef MEM_DUMP_CHECKSUM_EN
        if (csum_mode) tail <= 1'b1;
        else           csum <= csum + tx_byte;
`endif
      end
      if (state == ST_SEND && tail && uart_stop_ending) begin
        tail <= 1'b0;
`ifdef MEM_DUMP_CHECKSUM_EN
        if (!csum_mode) begin
          remaining <= remaining - (ADDR_W+1)'(1);
          if (last_word) csum_mode <= 1'b1;
          else           addr      <= addr + ADDR_W'(1);
        end
`else
        remaining <= remaining - (ADDR_W+1)'(1);
        if (!last_word) addr <= addr + ADDR_W'(1);
`endif
      end
    end
  end

  uart_tx_byte #(.BAUD_DIV(BAUD_DIV)) u_uart (
    .clk         (clk),
    .rst_n       (rst_n),
    .load        (uart_load),
    .data        (tx_byte),
    .ready       (uart_ready),
    .stop_ending (uart_stop_ending),
    .tx          (tx)
  );

  assign mem_addr = addr;
  assign busy     = (state != ST_IDLE);
  assign done     = done_r;

endmodule

// File: tb/tb_mem_dump_uart.sv
// Self-checking bench for mem_dump_uart: table-driven dumps, random dumps
// against a byte/timing model, reset-abort sequence.
module tb_mem_dump_uart;

  localparam int BAUD  = 4;
  localparam int FRAME = 10 * BAUD;
  localparam int WORD_T = 4 * FRAME + 2;
`ifdef MEM_DUMP_CHECKSUM_EN
  localparam int CS_EXTRA = FRAME;
`else
  localparam int CS_EXTRA = 0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [11:0] start_addr = '0;
  logic [12:0] word_count = '0;
  logic        mem_rd_en;
  logic [11:0] mem_addr;
  logic [31:0] mem_rdata = '0;
  logic        tx, busy, done;

  mem_dump_uart #(.ADDR_W(12), .DATA_W(32), .BAUD_DIV(BAUD)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .start_addr (start_addr),
    .word_count (word_count),
    .mem_rd_en  (mem_rd_en),
    .mem_addr   (mem_addr),
    .mem_rdata  (mem_rdata),
    .tx         (tx),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  logic [31:0]  mem [4096];
  int           cyc = 0;
  logic [11:0]  rd_q[$];
  byte unsigned rx_q[$];
  int           rx_t[$];
  int           done_q[$];
  logic         done_busy_q[$];
  int           frame_err = 0;
  int           checks = 0;
  int           failures = 0;

  byte unsigned exp_b[$];
  int           exp_t[$];
  logic [11:0]  exp_a[$];
  int           exp_lat;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_rd_en) begin
      mem_rdata <= mem[mem_addr];
      rd_q.push_back(mem_addr);
    end
  end

  always @(negedge clk) begin
    if (done) begin
      done_q.push_back(cyc);
      done_busy_q.push_back(busy);
    end
  end

  // UART receiver: frame start = cycle of the falling edge, bits sampled mid-bit
  initial begin : monitor
    forever begin
      @(negedge clk);
      if (rst_n && tx == 1'b0) begin
        int s;
        logic [9:0] bits;
        bit ok;
        s = cyc;
        ok = 1'b1;
        repeat (BAUD / 2) @(negedge clk);
        for (int i = 0; i < 10; i++) begin
          if (i > 0) repeat (BAUD) @(negedge clk);
          if (!rst_n) ok = 1'b0;
          bits[i] = tx;
        end
        if (ok) begin
          if (bits[0] !== 1'b0 || bits[9] !== 1'b1) frame_err++;
          rx_q.push_back(bits[8:1]);
          rx_t.push_back(s);
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic clear_obs();
    rd_q.delete();
    rx_q.delete();
    rx_t.delete();
    done_q.delete();
    done_busy_q.delete();
  endtask

  // Reference: bytes MSB-first per word, words 4 frames back-to-back, 2 idle cycles between words
  task automatic model(input int sa, input int cnt);
    byte unsigned sum;
    int t_end;
    exp_b.delete();
    exp_t.delete();
    exp_a.delete();
    sum = 0;
    t_end = 2;
    for (int w = 0; w < cnt; w++) begin
      logic [11:0] a;
      logic [31:0] d;
      a = 12'((sa + w) % 4096);
      d = mem[a];
      exp_a.push_back(a);
      for (int b = 0; b < 4; b++) begin
        byte unsigned v;
        v = 8'(d >> (8 * (3 - b)));
        exp_b.push_back(v);
        exp_t.push_back(3 + w * WORD_T + b * FRAME);
        sum = sum + v;
      end
      t_end = 3 + w * WORD_T + 4 * FRAME;
    end
`ifdef MEM_DUMP_CHECKSUM_EN
    exp_b.push_back(sum);
    exp_t.push_back(t_end);
    t_end = t_end + FRAME;
`endif
    exp_lat = t_end;
  endtask

  task automatic run_dump(input int sa, input int cnt, input bit restart, input int tab_lat,
                          input string tag);
    int k;
    model(sa, cnt);
    @(negedge clk);
    clear_obs();
    start_addr = 12'(sa);
    word_count = 13'(cnt);
    start = 1'b1;
    k = cyc + 1;
    @(negedge clk);
    start = 1'b0;
    check($sformatf("%s_busy_after_start", tag), 64'(busy), 64'(1));
    for (int i = 0; i < exp_lat + 100; i++) begin
      if (done_q.size() != 0) break;
      @(negedge clk);
      if (restart && cyc == k + 100) begin
        start_addr = 12'(sa + 33);
        word_count = 13'd1;
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    repeat (20) @(negedge clk);
    check($sformatf("%s_done_count", tag), 64'(done_q.size()), 64'(1));
    if (done_q.size() > 0) begin
      check($sformatf("%s_done_lat", tag), 64'(done_q[0] - k), 64'(exp_lat));
      check($sformatf("%s_busy_at_done", tag), 64'(done_busy_q[0]), 64'(0));
      if (tab_lat >= 0)
        check($sformatf("%s_done_lat_table", tag), 64'(done_q[0] - k), 64'(tab_lat + CS_EXTRA));
    end
    check($sformatf("%s_rd_count", tag), 64'(rd_q.size()), 64'(exp_a.size()));
    for (int i = 0; i < rd_q.size() && i < exp_a.size(); i++)
      check($sformatf("%s_rd_addr%0d", tag, i), 64'(rd_q[i]), 64'(exp_a[i]));
    check($sformatf("%s_byte_count", tag), 64'(rx_q.size()), 64'(exp_b.size()));
    for (int i = 0; i < rx_q.size() && i < exp_b.size(); i++) begin
      check($sformatf("%s_byte%0d", tag, i), 64'(rx_q[i]), 64'(exp_b[i]));
      check($sformatf("%s_byte%0d_time", tag, i), 64'(rx_t[i] - k), 64'(exp_t[i]));
    end
  endtask

  typedef struct {
    int sa;
    int cnt;
    bit restart;
    int lat;
  } vec_t;

  initial begin : main
    vec_t tab[5];
    int k;
    tab[0] = '{5,    1, 1'b0, 163};
    tab[1] = '{4095, 2, 1'b0, 325};
    tab[2] = '{0,    0, 1'b0, 2};
    tab[3] = '{10,   3, 1'b1, 487};
    tab[4] = '{100,  4, 1'b0, 649};

    for (int i = 0; i < 4096; i++) mem[i] = $urandom;
    mem[5]    = 32'hDEADBEEF;
    mem[4095] = 32'h01020304;
    mem[0]    = 32'hA0B0C0D0;
    mem[20]   = 32'h00000000;

    repeat (3) @(negedge clk);
    check("reset_tx", 64'(tx), 64'(1));
    check("reset_busy", 64'(busy), 64'(0));
    check("reset_done", 64'(done), 64'(0));
    check("reset_rd_en", 64'(mem_rd_en), 64'(0));
    check("reset_addr", 64'(mem_addr), 64'(0));
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    for (int v = 0; v < 5; v++)
      run_dump(tab[v].sa, tab[v].cnt, tab[v].restart, tab[v].lat, $sformatf("tab%0d", v));

`ifdef MEM_DUMP_CHECKSUM_EN
    run_dump(4095, 1, 1'b0, -1, "csum");
    check("csum_fifth_byte", 64'(rx_q.size() > 4 ? rx_q[4] : 8'hFF), 64'h0A);
`endif

    for (int r = 0; r < 5; r++)
      run_dump(int'($urandom_range(0, 4095)), int'($urandom_range(0, 3)), 1'b0, -1,
               $sformatf("rnd%0d", r));

    // Reset in the middle of the second byte of a zero word: tx must rise at once
    @(negedge clk);
    clear_obs();
    start_addr = 12'd20;
    word_count = 13'd2;
    start = 1'b1;
    k = cyc + 1;
    @(negedge clk);
    start = 1'b0;
    while (cyc < k + 3 + FRAME + 5 * BAUD + 1) @(negedge clk);
    check("abort_tx_low_before", 64'(tx), 64'(0));
    #2 rst_n = 1'b0;
    #1;
    check("abort_tx", 64'(tx), 64'(1));
    check("abort_busy", 64'(busy), 64'(0));
    check("abort_rd_en", 64'(mem_rd_en), 64'(0));
    check("abort_addr", 64'(mem_addr), 64'(0));
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (60) @(negedge clk);
    check("abort_no_done", 64'(done_q.size()), 64'(0));
    run_dump(50, 1, 1'b0, 163, "after_abort");

    check("frame_errors", 64'(frame_err), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
